fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_mul_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - two-requester round-robin arbiter around one shared FP32 multiplier
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   req0_valid/req0_ready  requester-0 handshake; ready is combinational, high only on its grant cycle
//   req0_a, req0_b         requester-0 operands (IEEE-754 single-precision layout)
//   req1_*                 same as req0_* for requester 1
//   res_valid/res_ready    result handshake; result held stable until accepted
//   res_data               truncated product of the granted operands
//   res_tag                index of the requester that owns res_data
//   busy                   high whenever an operation is in flight (state not IDLE)
//   op_count               number of results consumed, wraps at 16 bits

module fp_mul_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_tag,
  output logic            busy,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic            tag_q;
  logic            last_q;      // requester granted most recently
  logic            res_valid_q;
  logic [XLEN-1:0] res_data_q;
  logic            res_tag_q;
  logic [15:0]     op_count_q;

  // ---------------------------------------------------------------
  // Arbitration: only in IDLE and never while reset is asserted.
  // Contested requests go to the requester that did not win last.
  // ---------------------------------------------------------------
  logic grant_any;
  logic grant_idx;

  assign grant_any = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign grant_idx = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  assign req0_ready = grant_any && !grant_idx;
  assign req1_ready = grant_any &&  grant_idx;

  // ---------------------------------------------------------------
  // Truncating FP32 multiply of the captured operands.
  // Only the top 25 bits of the 48-bit mantissa product matter:
  // bit 24 here is P[47], which selects the normalisation shift.
  // ---------------------------------------------------------------
  logic [24:0]     prod_hi;
  logic [7:0]      exp_sum;
  logic [7:0]      exp_d;
  logic [22:0]     mant_d;
  logic            sign_d;
  logic [XLEN-1:0] res_data_d;
  logic [15:0]     op_count_d;

  assign prod_hi = 25'((48'({1'b1, op_a_q[22:0]}) * 48'({1'b1, op_b_q[22:0]})) >> 23);
  // 8-bit arithmetic gives the modulo-256 exponent wrap for free.
  assign exp_sum = op_a_q[30:23] + op_b_q[30:23] - 8'd127;
  assign exp_d   = prod_hi[24] ? (exp_sum + 8'd1) : exp_sum;
  assign mant_d  = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
  assign sign_d  = op_a_q[31] ^ op_b_q[31];

  assign res_data_d = {sign_d, exp_d, mant_d};
  assign op_count_d = op_count_q + 16'd1;

  // ---------------------------------------------------------------
  // Control FSM with registered result outputs.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      tag_q       <= 1'b0;
      last_q      <= 1'b1;      // makes requester 0 win the first contested grant
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            op_a_q  <= grant_idx ? req1_a : req0_a;
            op_b_q  <= grant_idx ? req1_b : req0_b;
            tag_q   <= grant_idx;
            last_q  <= grant_idx;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_data_q  <= res_data_d;
          res_tag_q   <= tag_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter

module tb_fp_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_tag;
  logic        busy;
  logic [15:0] op_count;

  fp_mul_arbiter #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Reference FP32 truncating multiply from plain integer arithmetic.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p, m;
    int e;
    logic s;
    s  = a[31] ^ b[31];
    ma = 64'(a[22:0]) + 64'd8388608;
    mb = 64'(b[22:0]) + 64'd8388608;
    p  = ma * mb;
    e  = (int'(a[30:23]) + int'(b[30:23]) + 256 - 127) % 256;
    if (p >= 64'd140737488355328) begin       // 2^47
      m = (p / 64'd16777216) % 64'd8388608;
      e = (e + 1) % 256;
    end else begin
      m = (p / 64'd8388608) % 64'd8388608;
    end
    return {s, 8'(e), 23'(m)};
  endfunction

  // ---------------------------------------------------------------
  // Transaction-level model: one operation outstanding at a time,
  // result visible two cycles after its grant until accepted.
  // ---------------------------------------------------------------
  int          cyc = 0;
  bit          m_inflight = 0;
  int          m_gc = 0;
  bit          m_last = 1;
  bit          m_tag = 0;
  logic [31:0] m_res = '0;
  logic [15:0] m_count = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    bit w;
    if (rst) begin
      m_inflight = 0;
      m_last     = 1;
      m_count    = '0;
    end else if (!m_inflight && (req0_valid || req1_valid)) begin
      w          = (req0_valid && req1_valid) ? !m_last : req1_valid;
      m_last     = w;
      m_tag      = w;
      m_res      = w ? fp_mul(req1_a, req1_b) : fp_mul(req0_a, req0_b);
      m_inflight = 1;
      m_gc       = cyc;
    end else if (m_inflight && cyc >= m_gc + 2 && res_ready) begin
      m_inflight = 0;
      m_count    = m_count + 16'd1;
    end
    cyc++;
  end

  // Grant log observed from the DUT: {tag, cycle}.
  int g_tag[$];
  int g_cyc[$];

  always @(negedge clk) begin
    bit e0, e1, ev, w;
    if (chk_en) begin
      e0 = 0;
      e1 = 0;
      if (!rst && !m_inflight && (req0_valid || req1_valid)) begin
        w  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e0 = !w;
        e1 = w;
      end
      ev = m_inflight && (cyc >= m_gc + 2);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      check("res_valid",  32'(res_valid),  32'(ev));
      check("busy",       32'(busy),       32'(m_inflight));
      check("op_count",   32'(op_count),   32'(m_count));
      if (ev) begin
        check("res_data", res_data,        m_res);
        check("res_tag",  32'(res_tag),    32'(m_tag));
      end
      if (req0_ready) begin g_tag.push_back(0); g_cyc.push_back(cyc); end
      if (req1_ready) begin g_tag.push_back(1); g_cyc.push_back(cyc); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0;
    req1_valid = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  // Single uncontested operation with res_ready held high.
  task automatic run_one(input bit idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [15:0] cnt);
    step();
    res_ready = 1;
    if (idx) begin req1_a = a; req1_b = b; req1_valid = 1; end
    else     begin req0_a = a; req0_b = b; req0_valid = 1; end
    @(negedge clk);
    check("grant_ready", 32'(idx ? req1_ready : req0_ready), 32'd1);
    step();
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
    check("calc_valid_low", 32'(res_valid), 32'd0);
    step();
    @(negedge clk);
    check("t2_valid", 32'(res_valid), 32'd1);
    check("t2_data",  res_data, exp);
    check("t2_tag",   32'(res_tag), 32'(idx));
    step();
    @(negedge clk);
    check("done_valid_low", 32'(res_valid), 32'd0);
    check("done_count", 32'(op_count), 32'(cnt));
  endtask

  typedef struct {
    bit          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6] = '{
    '{0, 32'h40000000, 32'h40400000, 32'h40C00000},   // 2.0 * 3.0
    '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000},   // 1.5 * 1.5, P[47]=1
    '{1, 32'hC0000000, 32'h40400000, 32'hC0C00000},   // -2.0 * 3.0
    '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000},   // 1.0 * 1.0
    '{1, 32'h7F000000, 32'h7F000000, 32'h3E800000},   // exponent wraps mod 256
    '{0, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE}    // truncation, no rounding
  };

  initial begin
    int done;
    bit seen;
    bit ok;

    // Reset with both requesters valid: readys must stay low.
    req0_valid = 1;
    req1_valid = 1;
    @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  res_data,       32'd0);
    check("rst_res_tag",   32'(res_tag),   32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("model_pin_a", fp_mul(32'h40000000, 32'h40400000), 32'h40C00000);
    check("model_pin_b", fp_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
    step();
    req0_valid = 0;
    req1_valid = 0;
    rst = 0;

    // Directed single operations.
    foreach (vecs[i]) run_one(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp, 16'(i + 1));

    // Contested, held requests after reset: grants alternate 0,1,0 every 3 cycles.
    do_reset();
    g_tag.delete();
    g_cyc.delete();
    req0_a = 32'h40000000; req0_b = 32'h40400000;
    req1_a = 32'h3FC00000; req1_b = 32'h3FC00000;
    req0_valid = 1;
    req1_valid = 1;
    res_ready  = 1;
    for (int k = 0; k < 30 && g_tag.size() < 3; k++) step();
    req0_valid = 0;
    req1_valid = 0;
    check("rr_grants", 32'(g_tag.size()), 32'd3);
    if (g_tag.size() >= 3) begin
      check("rr_tag0", 32'(g_tag[0]), 32'd0);
      check("rr_tag1", 32'(g_tag[1]), 32'd1);
      check("rr_tag2", 32'(g_tag[2]), 32'd0);
      check("rr_gap1", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
      check("rr_gap2", 32'(g_cyc[2] - g_cyc[1]), 32'd3);
    end
    repeat (4) step();

    // Back-pressure: result held for 5 cycles; inputs changing meanwhile.
    req0_a = 32'h40000000; req0_b = 32'h40400000;
    req0_valid = 1;
    res_ready  = 0;
    step();
    req0_valid = 0;
    req0_a = 32'hDEADBEEF;
    req1_valid = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data",  res_data, 32'h40C00000);
      check("hold_tag",   32'(res_tag), 32'd0);
      check("hold_r1rdy", 32'(req1_ready), 32'd0);
      check("hold_count", 32'(op_count), 32'd3);
      step();
    end
    res_ready = 1;
    @(negedge clk);
    check("hold_last_valid", 32'(res_valid), 32'd1);
    step();
    @(negedge clk);
    check("hold_done_valid", 32'(res_valid), 32'd0);
    check("hold_done_count", 32'(op_count), 32'd4);
    step();
    req1_valid = 0;
    repeat (4) step();

    // Reset during CALC discards the operation and restores the pointer.
    req0_a = 32'h40000000; req0_b = 32'h40400000;
    req0_valid = 1;
    @(negedge clk);
    check("abort_grant", 32'(req0_ready), 32'd1);
    step();
    rst = 1;
    req1_valid = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_count", 32'(op_count), 32'd0);
    check("abort_r0rdy", 32'(req0_ready), 32'd1);
    check("abort_r1rdy", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0;
    req1_valid = 0;
    repeat (4) step();

    // 65536 completions: op_count passes 0xFFFF and wraps to 0.
    do_reset();
    res_ready  = 1;
    req0_valid = 1;
    done = 0;
    seen = 0;
    ok   = 0;
    for (int k = 0; k < 65536 * 3 + 100; k++) begin
      @(negedge clk);
      if (done == 65535 && !seen) begin
        check("wrap_ffff", 32'(op_count), 32'h0000FFFF);
        seen = 1;
      end
      if (res_valid) done++;
      if (done == 65536) begin ok = 1; break; end
      step();
      req0_a = 32'h3F800000 | (32'(k) & 32'h007FFFFF);
      req0_b = 32'h40000000 | ((32'(k) * 32'd7) & 32'h007FFFFF);
    end
    check("wrap_reached", 32'(ok), 32'd1);
    step();
    req0_valid = 0;
    @(negedge clk);
    check("wrap_zero", 32'(op_count), 32'd0);
    step();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
